fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and decode. It buffers up to DEPTH fetched (PC, instruction) pairs so that a decode stall does not lose an instruction already read from instruction memory. It is flushed when a branch is taken. Its `enq_ready` drives the fetch stage's `enable` input, so fetch holds its PC while the queue is full.

## Interface
Parameters:
- `size`, 64: PC width.
- `DEPTH`, 4: number of entries. Must be a power of two and ≥ 2; elaboration fails otherwise.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `flush`  in  1  discard all entries (driven by `PCSrc` of the taken branch).
- `enq_valid`  in  1  fetch presents an instruction.
- `enq_ready`  out  1  queue can accept; drives fetch `enable`.
- `enq_pc`  in  `size`  PC of the presented instruction (fetch `imem_addr_F`).
- `enq_instr`  in  32  instruction word read from imem.
- `deq_valid`  out  1  head entry present.
- `deq_ready`  in  1  decode consumes the head this cycle.
- `deq_pc`  out  `size`  PC of head entry.
- `deq_instr`  out  32  instruction of head entry.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
State:
- `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrap modulo DEPTH.
- `count`, 0..DEPTH.
- Entry array `mem[DEPTH]`.

Signals and rules:
- `enq_ready = (count != DEPTH)`. No write-through when full: a dequeue in the same cycle does not free a slot for that cycle.
- `deq_valid = (count != 0)`.
- `deq_pc` / `deq_instr`:
  - equal `mem[rd_ptr]` when `deq_valid` = 1;
  - forced to 0 when `deq_valid` = 0, so decode sees a zero bubble.
- `enq_fire = enq_valid & enq_ready & ~flush`; `deq_fire = deq_valid & deq_ready & ~flush`.

Per rising edge, in priority order:
1. `flush` = 1: `wr_ptr`, `rd_ptr` and `count` go to 0. Any enqueue or dequeue requested in that cycle is dropped. `mem` contents are left untouched.
2. Otherwise:
   - `enq_fire`: write `mem[wr_ptr] ← {enq_pc, enq_instr}`, then `wr_ptr++`.
   - `deq_fire`: `rd_ptr++`.
   - `count`: +1 when only enqueueing, −1 when only dequeueing, unchanged when both or neither.
   - Both fire at `count` = 1: the old head leaves and the new entry becomes the head; `count` stays 1.

Further rules:
- `enq_valid` asserted while `enq_ready` = 0: no effect. Fetch is already stalled through `enable`.
- `deq_ready` asserted while empty: no effect; `count` never underflows.
- `count` never exceeds DEPTH.

## Timing
- Reset: while `reset` is high, independent of `clk`:
  - `wr_ptr`, `rd_ptr`, `count` = 0 and every `mem` entry = 0;
  - so `deq_valid` = 0, `deq_pc` = 0, `deq_instr` = 0, `enq_ready` = 1.
- Reset asserted mid-operation discards all entries immediately.
- Latency: no fall-through. An entry written at edge t is visible on `deq_*` at edge t+1 at the earliest.
- `enq_ready`, `deq_valid`, `count` and `deq_*` are functions of registered state only. They do not combinationally depend on `enq_valid`, `deq_ready` or `flush`, so there are no paths from inputs to these outputs.
- Flush takes effect at the edge it is sampled. The next cycle shows `deq_valid` = 0 and `enq_ready` = 1. The first post-branch fetch can be enqueued in that cycle.

## Structure
- Shared package `pipe_pkg`:
  - `INSTR_W = 32`;
  - `typedef struct packed {logic [size-1:0] pc; logic [INSTR_W-1:0] instr;} fq_entry_t`, with `size` fixed at 64 in the package.
- Decode and the hazard unit reuse `fq_entry_t`.
- One sub-module, `wrap_counter #(W)`:
  - ports: clk, async reset, clear, increment;
  - used for both `wr_ptr` and `rd_ptr`.
- Occupancy counter and array stay inline.

## Test plan
- Reset, then 4 enqueues of PCs 0x0, 0x4, 0x8, 0xC with `deq_ready` = 0 → `count` = 4, `enq_ready` = 0. A 5th `enq_valid` is ignored and `deq_pc` stays 0x0.
- Full queue, `deq_ready` = 1 for 4 cycles → `deq_pc` sequence 0x0, 0x4, 0x8, 0xC, then `deq_valid` = 0 with `deq_pc`/`deq_instr` = 0.
- Steady streaming with `enq_valid` = `deq_ready` = 1 for 10 cycles from empty, PCs +4 each → `count` reaches 1 and holds. Output lags input by one cycle and pointers wrap past DEPTH without loss or reorder.
- Three entries held, then `flush` = 1 together with `enq_valid` (PC 0x100) and `deq_ready` → next cycle `count` = 0 and `deq_valid` = 0, and 0x100 is never dequeued. Enqueue 0x200 the following cycle → it appears one cycle later.
- `reset` pulsed asynchronously between clock edges with 2 entries held → outputs go to reset values before the next edge, and subsequent operation starts from empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: the fetched (PC, instruction) pair used by the
// fetch queue, decode and the hazard unit.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned size    = 64;

    typedef struct packed {
        logic [size-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Enqueue/dequeue handshake bundle between fetch, the fetch queue and decode.
// master: the fetch/decode side driving the queue; slave: the queue itself.
interface fetch_queue_if #(
    parameter int unsigned size  = 64,
    parameter int unsigned DEPTH = 4
);
    import pipe_pkg::*;

    logic                       enq_valid;
    logic                       enq_ready;
    logic [size-1:0]            enq_pc;
    logic [INSTR_W-1:0]         enq_instr;
    logic                       deq_valid;
    logic                       deq_ready;
    logic [size-1:0]            deq_pc;
    logic [INSTR_W-1:0]         deq_instr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output enq_valid, enq_pc, enq_instr, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, count
    );

endinterface

// File: rtl/fetch_queue_wrap_counter.sv
// W-bit pointer that wraps naturally modulo 2**W; used for the queue
// read and write pointers.
module wrap_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Clear wins over increment; wrap comes for free from the W-bit width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (inc)
            value <= value + 1'b1;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Buffers up to DEPTH
// (PC, instruction) pairs, is flushed on a taken branch, and exposes
// enq_ready as the fetch-stage enable. All outputs come from registered
// state only; there is no fall-through path from enqueue to dequeue.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int unsigned size  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    fetch_queue_if.slave q
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_q;
    logic [size-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic               enq_ready;
    logic               deq_valid;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_ready = (count_q != FULL);
    assign deq_valid = (count_q != '0);
    assign enq_fire  = q.enq_valid & enq_ready & ~flush;
    assign deq_fire  = q.deq_ready & deq_valid & ~flush;

    assign q.enq_ready = enq_ready;
    assign q.deq_valid = deq_valid;
    assign q.count     = count_q;
    assign q.deq_pc    = deq_valid ? mem_pc[rd_ptr]    : '0;
    assign q.deq_instr = deq_valid ? mem_instr[rd_ptr] : '0;

    wrap_counter #(.W(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (enq_fire),
        .value (wr_ptr)
    );

    wrap_counter #(.W(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (deq_fire),
        .value (rd_ptr)
    );

    // Occupancy: flush empties; simultaneous enqueue and dequeue cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (flush)
            count_q <= '0;
        else begin
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: cleared on reset, untouched by flush, written on enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (enq_fire) begin
            mem_pc[wr_ptr]    <= q.enq_pc;
            mem_instr[wr_ptr] <= q.enq_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (size 64, DEPTH 4).
module tb_fetch_queue;

    logic clk;
    logic reset;
    logic flush;
    int   n_cmp;
    int   n_err;

    fetch_queue_if #(.size(64), .DEPTH(4)) bus ();

    fetch_queue #(.size(64), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [63:0] pc, input logic dr);
        bus.enq_valid = ev;
        bus.enq_pc    = pc;
        bus.enq_instr = instr_of(pc);
        bus.deq_ready = dr;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 64'(bus.count), 64'd0);
        chk({tag, "_deq_valid"}, 64'(bus.deq_valid), 64'd0);
        chk({tag, "_enq_ready"}, 64'(bus.enq_ready), 64'd1);
        chk({tag, "_deq_pc"}, bus.deq_pc, 64'd0);
        chk({tag, "_deq_instr"}, 64'(bus.deq_instr), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 64'd0, 1'b0);

        // Reset state
        #12;
        chk_empty("reset");
        reset = 1'b0;
        cyc();

        // Fill with 0x0, 0x4, 0x8, 0xC; no fall-through before the edge
        drive(1'b1, 64'h0, 1'b0);
        #1;
        chk("no_fallthrough", 64'(bus.deq_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 1'b0);
            cyc();
            chk("fill_count", 64'(bus.count), 64'(i + 1));
        end
        chk("full_enq_ready", 64'(bus.enq_ready), 64'd0);
        chk("full_head_pc", bus.deq_pc, 64'h0);
        chk("full_head_instr", 64'(bus.deq_instr), 64'(instr_of(64'h0)));

        // Fifth enqueue while full is ignored
        drive(1'b1, 64'h10, 1'b0);
        cyc();
        chk("overfill_count", 64'(bus.count), 64'd4);
        chk("overfill_head_pc", bus.deq_pc, 64'h0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            #1;
            chk("drain_pc", bus.deq_pc, 64'(4 * i));
            chk("drain_instr", 64'(bus.deq_instr), 64'(instr_of(64'(4 * i))));
            cyc();
        end
        chk_empty("drained");

        // Dequeue while empty has no effect
        drive(1'b0, 64'h0, 1'b1);
        cyc();
        chk("underflow_count", 64'(bus.count), 64'd0);

        // Streaming: one-cycle lag, count holds at 1, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'(64'h40 + 4 * i), 1'b1);
            if (i > 0) begin
                #1;
                chk("stream_head_pre", bus.deq_pc, 64'(64'h40 + 4 * (i - 1)));
            end
            cyc();
            chk("stream_count", 64'(bus.count), 64'd1);
            chk("stream_head", bus.deq_pc, 64'(64'h40 + 4 * i));
            chk("stream_instr", 64'(bus.deq_instr), 64'(instr_of(64'(64'h40 + 4 * i))));
        end
        drive(1'b0, 64'h0, 1'b1);
        cyc();
        chk_empty("stream_end");

        // Flush with three entries held, racing enqueue and dequeue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(64'h80 + 4 * i), 1'b0);
            cyc();
        end
        chk("preflush_count", 64'(bus.count), 64'd3);
        chk("preflush_head", bus.deq_pc, 64'h80);
        drive(1'b1, 64'h100, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_empty("flushed");
        drive(1'b1, 64'h200, 1'b0);
        #1;
        chk("post_flush_latency", 64'(bus.deq_valid), 64'd0);
        cyc();
        chk("post_flush_count", 64'(bus.count), 64'd1);
        chk("post_flush_head", bus.deq_pc, 64'h200);
        drive(1'b0, 64'h0, 1'b1);
        cyc();
        chk_empty("post_flush_drain");

        // Asynchronous reset between edges with two entries held
        drive(1'b1, 64'h300, 1'b0);
        cyc();
        drive(1'b1, 64'h304, 1'b0);
        cyc();
        drive(1'b0, 64'h0, 1'b0);
        chk("prereset_count", 64'(bus.count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_empty("async_reset");
        #1;
        reset = 1'b0;
        drive(1'b1, 64'h400, 1'b0);
        cyc();
        chk("after_reset_count", 64'(bus.count), 64'd1);
        chk("after_reset_head", bus.deq_pc, 64'h400);
        drive(1'b0, 64'h0, 1'b1);
        cyc();
        chk_empty("after_reset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
